// File: rtl/serial_deserializer.sv
// Start-framed serial receiver: rebuilds MSB-first words and queues them
// in a small FIFO behind a valid/ready port.
module serial_deserializer #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             start_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(BIT_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic             state;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    bit_cnt;
    logic [PW-1:0]    phase;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             sample;
    logic             done;
    logic             early;
    logic [WIDTH-1:0] word;
    logic             full;
    logic             empty;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign sample = (state == SHIFT) && (phase == LAST_PH);
    assign done   = sample && (bit_cnt == LAST_BIT);
    // A start that lands on the LSB sample is ignored: completion wins.
    assign early  = (state == SHIFT) && start_in && !done;
    assign word   = {shift[WIDTH-2:0], serial_in};

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign pop    = !empty && ready_in;
    assign wr_en  = done && (!full || pop);
    assign drop   = done && full && !pop;

    assign valid_out = !empty;
    assign data_out  = mem[rd_ptr];
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            phase   <= '0;
        end else if (done) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            phase   <= '0;
        end else if (start_in) begin
            state   <= SHIFT;
            shift   <= {{(WIDTH-1){1'b0}}, serial_in};
            bit_cnt <= CW'(1);
            phase   <= '0;
        end else if (state == SHIFT) begin
            if (sample) begin
                phase   <= '0;
                shift   <= word;
                bit_cnt <= bit_cnt + CW'(1);
            end else begin
                phase   <= phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= early;
            overflow  <= drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: one instance with single-cycle
// bits, one with three-cycle bits.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       ser1 = 1'b0, st1 = 1'b0, rdy1 = 1'b0;
    logic [7:0] d1;
    logic       v1, b1, fe1, ov1;

    logic       ser3 = 1'b0, st3 = 1'b0, rdy3 = 1'b0;
    logic [7:0] d3;
    logic       v3, b3, fe3, ov3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(8), .FIFO_DEPTH(2), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .serial_in(ser1), .start_in(st1),
        .data_out(d1), .valid_out(v1), .ready_in(rdy1), .busy(b1),
        .frame_err(fe1), .overflow(ov1)
    );

    serial_deserializer #(.WIDTH(8), .FIFO_DEPTH(2), .BIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .serial_in(ser3), .start_in(st3),
        .data_out(d3), .valid_out(v3), .ready_in(rdy3), .busy(b3),
        .frame_err(fe3), .overflow(ov3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit1(input logic s, input logic b);
        st1  = s;
        ser1 = b;
        @(negedge clk);
    endtask

    task automatic frame1(input logic [7:0] w);
        for (int i = 0; i < 8; i++) bit1(i == 0, w[7-i]);
        st1 = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_valid", 32'(v1), 0);
        chk("rst_busy", 32'(b1), 0);
        chk("rst_data", 32'(d1), 0);
        chk("rst_ferr", 32'(fe1), 0);
        chk("rst_ovf", 32'(ov1), 0);
        chk("rst_valid3", 32'(v3), 0);
        chk("rst_data3", 32'(d3), 0);

        // Single frame A5, valid exactly 8 cycles after start
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) chk("a5_busy", 32'(b1), 1);
            if (i == 7) chk("a5_not_early", 32'(v1), 0);
            bit1(i == 0, w[7-i]);
        end
        st1 = 1'b0;
        chk("a5_valid", 32'(v1), 1);
        chk("a5_data", 32'(d1), 'hA5);
        chk("a5_idle", 32'(b1), 0);
        tick();
        chk("a5_hold", 32'(d1), 'hA5);
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        chk("a5_popped", 32'(v1), 0);

        // Back-to-back with stalled consumer
        frame1(8'h3C);
        chk("b2b_ovf0", 32'(ov1), 0);
        frame1(8'hC3);
        chk("b2b_ovf1", 32'(ov1), 0);
        frame1(8'hFF);
        chk("b2b_ovf_pulse", 32'(ov1), 1);
        chk("b2b_head", 32'(d1), 'h3C);
        tick();
        chk("b2b_ovf_clear", 32'(ov1), 0);
        rdy1 = 1'b1;
        chk("b2b_rd0", 32'(d1), 'h3C);
        tick();
        chk("b2b_rd1_valid", 32'(v1), 1);
        chk("b2b_rd1", 32'(d1), 'hC3);
        tick();
        chk("b2b_empty", 32'(v1), 0);
        rdy1 = 1'b0;

        // Early start at bit 4, then full 81
        w = 8'hF0;
        for (int i = 0; i < 4; i++) bit1(i == 0, w[7-i]);
        w = 8'h81;
        for (int i = 0; i < 8; i++) begin
            bit1(i == 0, w[7-i]);
            if (i == 0) chk("early_ferr", 32'(fe1), 1);
            if (i == 0) chk("early_busy", 32'(b1), 1);
            if (i == 1) chk("early_ferr_clear", 32'(fe1), 0);
        end
        st1 = 1'b0;
        chk("early_valid", 32'(v1), 1);
        chk("early_data", 32'(d1), 'h81);
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        chk("early_only_one", 32'(v1), 0);

        // Start coincident with LSB sample: completion wins
        w = 8'h01;
        for (int i = 0; i < 8; i++) bit1(i == 0 || i == 7, w[7-i]);
        st1 = 1'b0;
        chk("lsb_start_ferr", 32'(fe1), 0);
        chk("lsb_start_busy", 32'(b1), 0);
        chk("lsb_start_data", 32'(d1), 'h01);
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        chk("lsb_start_pop", 32'(v1), 0);

        // BIT_CYCLES = 3: 5A valid 22 cycles after start
        w = 8'h5A;
        for (int j = 0; j < 24; j++) begin
            st3  = (j == 0);
            ser3 = w[7 - j/3];
            tick();
            if (j == 20) chk("bc3_not_early", 32'(v3), 0);
            if (j == 21) chk("bc3_valid", 32'(v3), 1);
            if (j == 21) chk("bc3_data", 32'(d3), 'h5A);
        end
        st3 = 1'b0;
        rdy3 = 1'b1;
        tick();
        rdy3 = 1'b0;
        chk("bc3_pop", 32'(v3), 0);

        // BIT_CYCLES = 3: start during a hold cycle aborts
        for (int j = 0; j < 5; j++) begin
            st3  = (j == 0);
            ser3 = 1'b1;
            tick();
        end
        w = 8'h24;
        for (int j = 0; j < 24; j++) begin
            st3  = (j == 0);
            ser3 = w[7 - j/3];
            tick();
            if (j == 0) chk("bc3_ferr", 32'(fe3), 1);
            if (j == 1) chk("bc3_ferr_clear", 32'(fe3), 0);
            if (j == 20) chk("bc3_abort_not_early", 32'(v3), 0);
            if (j == 21) chk("bc3_abort_data", 32'(d3), 'h24);
        end
        st3 = 1'b0;
        chk("bc3_abort_valid", 32'(v3), 1);
        rdy3 = 1'b1;
        tick();
        rdy3 = 1'b0;
        chk("bc3_abort_one", 32'(v3), 0);

        // Async reset mid-frame with a word buffered
        frame1(8'h77);
        w = 8'h3F;
        for (int i = 0; i < 5; i++) bit1(i == 0, w[7-i]);
        chk("ar_pre_busy", 32'(b1), 1);
        chk("ar_pre_valid", 32'(v1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(v1), 0);
        chk("ar_busy", 32'(b1), 0);
        chk("ar_data", 32'(d1), 0);
        st1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        frame1(8'h12);
        chk("ar_new_valid", 32'(v1), 1);
        chk("ar_new_data", 32'(d1), 'h12);
        chk("ar_new_ferr", 32'(fe1), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive side of the team's start-framed serial link.
- Reconstructs parallel words from a `serial_in` / `start_in` pair, e.g. the SAP-3 output-register stream or the register-file dump stream.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface to a consumer such as a checker, a display driver, or the sorter.
- Used on-chip in loopback builds and as the bench's reference decoder.

Parameters:
- WIDTH, 8: bits per frame.
- FIFO_DEPTH, 2: output buffer entries; power of two, ≥ 2.
- BIT_CYCLES, 1: `clk` cycles each bit is held on `serial_in`; ≥ 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data, MSB first.
- start_in  input  1  frame start; high for exactly one cycle, the first cycle of the MSB bit period.
- data_out  output  WIDTH  oldest buffered word.
- valid_out  output  1  `data_out` holds a valid word.
- ready_in  input  1  consumer accepts the word.
- busy  output  1  frame reception in progress.
- frame_err  output  1  one-cycle pulse: frame aborted by an early start.
- overflow  output  1  one-cycle pulse: completed word dropped because the FIFO was full.

Behaviour:
- Interface decisions:
  - One clock (`clk`); reset `rst_n` is asynchronous and active-low.
  - `serial_in` and `start_in` are synchronous to `clk`; no input synchronizers.
- Reset: all outputs 0, shift register 0, bit counter 0, phase counter 0, FIFO empty, state IDLE. Reset mid-frame discards the partial frame.
- State machine, two states:
  - IDLE: `busy` = 0. When `start_in` = 1, sample `serial_in` as the MSB into `shift[WIDTH-1]`, set bit_cnt = 1 and phase = 0, go to SHIFT.
  - SHIFT: `busy` = 1. phase counts 0..BIT_CYCLES-1 and wraps. The sample point is the cycle where phase wraps to 0, i.e. the first cycle of each bit period. At each sample point, shift `serial_in` in at the LSB side and increment bit_cnt.
  - Frame complete: when bit_cnt reaches WIDTH, push the assembled word into the FIFO and return to IDLE on the same edge.
- Latency: the word appears on `data_out` with `valid_out` = 1 in the cycle after the LSB sample, if the FIFO was empty.
- Back-to-back frames: `start_in` in the first cycle after completion is accepted normally (IDLE sees it). No gap cycles are required.
- Early start (`start_in` = 1 while in SHIFT with bit_cnt < WIDTH, on any phase):
  - Pulse `frame_err` for 1 cycle and discard the partial word.
  - Restart the frame in the same cycle: sample `serial_in` as the new MSB, bit_cnt = 1, phase = 0; remain in SHIFT.
- `start_in` in the same cycle the LSB is sampled: completion wins (no error); the start is not honoured as a new frame.
- FIFO:
  - `valid_out` = !empty; `data_out` = head entry (registered storage, combinational read of head).
  - Pop when `valid_out` && `ready_in`.
  - `data_out` is held stable while `valid_out` = 1 and `ready_in` = 0.
  - Push and pop in the same cycle are both performed, including when full; occupancy is unchanged.
  - Push when full without a pop: drop the new word, keep the stored contents, pulse `overflow` for 1 cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- `frame_err` and `overflow` can pulse independently in the same cycle.
- Widths: bit_cnt is clog2(WIDTH+1) bits; phase is clog2(BIT_CYCLES) bits, minimum 1.

Test Plan:
- Reset then idle: `rst_n` = 0 for 3 cycles, then 1 with `start_in` = 0 -> `valid_out` = 0, `busy` = 0, `data_out` = 0, no pulses.
- Single frame, WIDTH = 8, BIT_CYCLES = 1: `start_in` with bits 1,0,1,0,0,1,0,1 -> `data_out` = 8'hA5, `valid_out` = 1 exactly 8 cycles after the start cycle; `ready_in` = 1 -> `valid_out` = 0 next cycle.
- Back-to-back with consumer stalled, FIFO_DEPTH = 2:
  - Frames 8'h3C, 8'hC3, 8'hFF sent with no gaps and `ready_in` = 0 -> 2 words buffered, `overflow` pulses once at the third completion.
  - Then `ready_in` = 1 -> reads 8'h3C then 8'hC3, then `valid_out` = 0.
- Early start: new `start_in` at bit 4 of a frame, followed by the full frame 8'h81 -> `frame_err` pulses in the restart cycle; only 8'h81 is delivered.
- BIT_CYCLES = 3: each bit held 3 cycles, frame 8'h5A -> `data_out` = 8'h5A valid 22 cycles after start; `start_in` during a hold cycle aborts with `frame_err`.
- Asynchronous reset mid-frame: `rst_n` low at bit 5 of a frame -> all outputs 0 immediately; after release, a fresh 8'h12 frame is received correctly.
